// File: rtl/load_align_unit.sv
// Multi-cycle load unit: splits a load into one or two aligned word reads,
// merges straddling beats and sign/zero-extends the result for writeback.
module load_align_unit #(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1,
    parameter int TAG_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_fault
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [XLEN-1:0] NB_STEP = XLEN'(NB);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_fault_q, rsp_fault_d;

    logic              req_fault;
    logic              cur_span;
    logic [OFF_W-1:0]  cur_off;
    logic [XLEN-1:0]   base_addr;

    function automatic logic funct3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            3'b011, 3'b110:                         ok = (XLEN == 64);
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic spans_words(input logic [OFF_W-1:0] off, input logic [1:0] sz);
        logic [4:0] end_byte;
        end_byte = 5'(off) + (5'd1 << sz);
        return end_byte > 5'(NB);
    endfunction

    // Window the {beat1, beat0} pair at the byte offset, keep the access size
    // and extend from its top bit unless the load is unsigned.
    function automatic logic [XLEN-1:0] merge_extend(
        input logic [XLEN-1:0]  b0,
        input logic [XLEN-1:0]  b1,
        input logic [OFF_W-1:0] off,
        input logic [2:0]       f3
    );
        logic [2*XLEN-1:0] window;
        logic [XLEN-1:0]   raw;
        logic [XLEN-1:0]   keep;
        logic [XLEN-1:0]   top_sh;
        logic [XLEN-1:0]   res;
        int unsigned       nbits;
        window = {b1, b0} >> {off, 3'b000};
        raw    = window[XLEN-1:0];
        nbits  = 32'd8 << f3[1:0];
        if (nbits >= XLEN) begin
            keep = '1;
        end else begin
            keep = (ONE << nbits) - ONE;
        end
        top_sh = raw >> (nbits - 1);
        res    = raw & keep;
        if (!f3[2] && top_sh[0]) begin
            res = res | ~keep;
        end
        return res;
    endfunction

    assign req_fault = !funct3_legal(req_funct3) ||
                       (!MISALIGNED_EN && spans_words(req_addr[OFF_W-1:0], req_funct3[1:0]));
    assign cur_off   = addr_q[OFF_W-1:0];
    assign cur_span  = spans_words(cur_off, funct3_q[1:0]);
    assign base_addr = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        beat0_d     = beat0_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    funct3_d  = req_funct3;
                    rsp_tag_d = req_tag;
                    if (req_fault) begin
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = S_RESP;
                    end else begin
                        rsp_fault_d = 1'b0;
                        state_d     = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rsp_data;
                    if (cur_span) begin
                        state_d = S_REQ1;
                    end else begin
                        rsp_data_d = merge_extend(mem_rsp_data, '0, cur_off, funct3_q);
                        state_d    = S_RESP;
                    end
                end
            end
            S_REQ1: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    rsp_data_d = merge_extend(beat0_q, mem_rsp_data, cur_off, funct3_q);
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            beat0_q     <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            beat0_q     <= beat0_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // The read address is only driven while a read is being offered.
    always_comb begin
        req_ready     = (state_q == S_IDLE);
        mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
        rsp_valid     = (state_q == S_RESP);
        mem_req_addr  = '0;
        if (state_q == S_REQ0) begin
            mem_req_addr = base_addr;
        end else if (state_q == S_REQ1) begin
            mem_req_addr = base_addr + NB_STEP;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_fault = rsp_fault_q;

endmodule
